// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module : core_pkg
// Brief  : Shared core constants: datapath width, ctrl bit positions, load
//          funct3 encodings.
// Rev    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN = 32;

  localparam int c_ctrl_branch     = 5;
  localparam int c_ctrl_mem_read   = 4;
  localparam int c_ctrl_mem_write  = 3;
  localparam int c_ctrl_reg_write  = 2;
  localparam int c_ctrl_mem_to_reg = 1;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } load_f3_e;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module : load_align
// Brief  : Combinational load-data extraction and misalignment detection.
// Rev    : 1.0 - initial release
// ============================================================================
module load_align
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      offset,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            misaligned
);

  logic [XLEN-1:0] w_shifted;

  assign w_shifted = word >> {offset, 3'b000};

  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:  data = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
      F3_LBU: data = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
      F3_LH: begin
        data       = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
        misaligned = (offset == 2'd3);
      end
      F3_LHU: begin
        data       = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
        misaligned = (offset == 2'd3);
      end
      F3_LW: begin
        data       = word;
        misaligned = (offset != 2'd0);
      end
      default: data = word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module : wb_stage
// Brief  : Write-back pipeline stage: one register, load alignment,
//          register-file write, forwarding and retired-instruction counter.
// Rev    : 1.0 - initial release
// ============================================================================
module wb_stage
  import core_pkg::*;
#(
  parameter int XLEN  = core_pkg::XLEN,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ms_valid,
  input  logic [5:0]       ms_ctrl,
  input  logic [2:0]       ms_funct3,
  input  logic [4:0]       ms_rd,
  input  logic [XLEN-1:0]  ms_alu_result,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             ws_stall,
  input  logic             ws_flush,
  output logic             ws_allowin,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             ws_fwd_valid,
  output logic [4:0]       ws_fwd_rd,
  output logic [XLEN-1:0]  ws_fwd_data,
  output logic [CNT_W-1:0] instret
);

  logic            r_ws_valid;
  logic [5:0]      r_ctrl;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_alu_result;
  logic [1:0]      r_offset;
  logic [CNT_W-1:0] r_instret;
  logic            misalign_err;

  logic [XLEN-1:0] w_load_data;
  logic            w_load_misaligned;
  logic            w_misaligned;
  logic            w_retire;
  logic            w_writes_rd;
  logic            w_unused_ctrl;

  load_align #(.XLEN(XLEN)) u_load_align (
    .word       (mem_rdata),
    .offset     (r_offset),
    .funct3     (r_funct3),
    .data       (w_load_data),
    .misaligned (w_load_misaligned)
  );

  // Alignment only matters for real loads; ALU ops share funct3 encodings.
  assign w_misaligned = r_ctrl[c_ctrl_mem_read] & w_load_misaligned;
  assign w_retire     = r_ws_valid & ~ws_stall;
  assign w_writes_rd  = r_ws_valid & r_ctrl[c_ctrl_reg_write] & (r_rd != 5'd0);

  assign ws_allowin   = ~ws_stall;
  assign rf_we        = w_writes_rd & ~ws_stall & ~w_misaligned;
  assign rf_waddr     = r_rd;
  assign rf_wdata     = r_ctrl[c_ctrl_mem_to_reg] ? w_load_data : r_alu_result;
  assign ws_fwd_valid = w_writes_rd;
  assign ws_fwd_rd    = r_rd;
  assign ws_fwd_data  = rf_wdata;
  assign instret      = r_instret;

  assign w_unused_ctrl = ^{r_ctrl[c_ctrl_branch], r_ctrl[c_ctrl_mem_write], r_ctrl[0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ws_valid   <= 1'b0;
      r_ctrl       <= 6'd0;
      r_funct3     <= 3'd0;
      r_rd         <= 5'd0;
      r_alu_result <= {XLEN{1'b0}};
      r_offset     <= 2'd0;
      r_instret    <= {CNT_W{1'b0}};
      misalign_err <= 1'b0;
    end else begin
      // A stall freezes the register outright, so it overrides a flush.
      if (ws_allowin) begin
        r_ws_valid <= ms_valid & ~ws_flush;
        if (ms_valid) begin
          r_ctrl       <= ms_ctrl;
          r_funct3     <= ms_funct3;
          r_rd         <= ms_rd;
          r_alu_result <= ms_alu_result;
          r_offset     <= ms_alu_result[1:0];
        end
      end
      if (w_retire) begin
        r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_retire && w_misaligned) begin
        misalign_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_stage
// Brief  : Scoreboard bench for wb_stage with directed load/ALU/stall vectors.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_wb_stage;

  localparam logic [5:0] c_load  = 6'b010110;
  localparam logic [5:0] c_alu   = 6'b000100;
  localparam logic [5:0] c_store = 6'b001000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ms_valid = 1'b0;
  logic [5:0]  ms_ctrl = '0;
  logic [2:0]  ms_funct3 = '0;
  logic [4:0]  ms_rd = '0;
  logic [31:0] ms_alu_result = '0;
  logic [31:0] mem_rdata = '0;
  logic        ws_stall = 1'b0;
  logic        ws_flush = 1'b0;
  logic        ws_allowin;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_fwd_valid;
  logic [4:0]  ws_fwd_rd;
  logic [31:0] ws_fwd_data;
  logic [63:0] instret;

  wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ms_valid      (ms_valid),
    .ms_ctrl       (ms_ctrl),
    .ms_funct3     (ms_funct3),
    .ms_rd         (ms_rd),
    .ms_alu_result (ms_alu_result),
    .mem_rdata     (mem_rdata),
    .ws_stall      (ws_stall),
    .ws_flush      (ws_flush),
    .ws_allowin    (ws_allowin),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .ws_fwd_valid  (ws_fwd_valid),
    .ws_fwd_rd     (ws_fwd_rd),
    .ws_fwd_data   (ws_fwd_data),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_instret = 64'd0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && rf_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected no write", rf_waddr, rf_wdata);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.rd});
        chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.data});
      end
    end
  end

  // Drive one instruction, supply its RAM word in the WB cycle, check
  // forwarding there and the retire count one edge later.
  task automatic run_instr(input logic [5:0] ctrl, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] alu,
                           input logic [31:0] rdata, input bit flush,
                           input bit exp_write, input bit exp_fwd,
                           input logic [31:0] exp_data);
    ms_valid      = 1'b1;
    ms_ctrl       = ctrl;
    ms_funct3     = f3;
    ms_rd         = rd;
    ms_alu_result = alu;
    ws_flush      = flush;
    @(posedge clk); #1;
    ms_valid  = 1'b0;
    ws_flush  = 1'b0;
    mem_rdata = rdata;
    if (exp_write) exp_q.push_back({rd, exp_data});
    if (!flush) exp_instret = exp_instret + 64'd1;
    #1;
    chk("ws_fwd_valid", {63'd0, ws_fwd_valid}, {63'd0, exp_fwd});
    if (exp_fwd) begin
      chk("ws_fwd_rd", {59'd0, ws_fwd_rd}, {59'd0, rd});
      chk("ws_fwd_data", {32'd0, ws_fwd_data}, {32'd0, exp_data});
    end
    @(posedge clk); #1;
    chk("instret", instret, exp_instret);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rf_we", {63'd0, rf_we}, 64'd0);
    chk("reset_fwd_valid", {63'd0, ws_fwd_valid}, 64'd0);
    chk("reset_instret", instret, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("allowin_idle", {63'd0, ws_allowin}, 64'd1);
    chk("idle_rf_we", {63'd0, rf_we}, 64'd0);

    // Aligned word load
    run_instr(c_load, 3'b010, 5'd5, 32'h100, 32'hDEADBEEF, 0, 1, 1, 32'hDEADBEEF);
    // Byte and halfword extraction from 0x80FF_0000
    run_instr(c_load, 3'b000, 5'd6, 32'h103, 32'h80FF0000, 0, 1, 1, 32'hFFFFFF80);
    run_instr(c_load, 3'b100, 5'd7, 32'h103, 32'h80FF0000, 0, 1, 1, 32'h00000080);
    run_instr(c_load, 3'b101, 5'd8, 32'h102, 32'h80FF0000, 0, 1, 1, 32'h000080FF);
    run_instr(c_load, 3'b001, 5'd9, 32'h102, 32'h80FF0000, 0, 1, 1, 32'hFFFF80FF);
    run_instr(c_load, 3'b000, 5'd10, 32'h101, 32'h12345678, 0, 1, 1, 32'h00000056);
    // ALU results, rd=0 suppression, store
    run_instr(c_alu, 3'b000, 5'd0, 32'h55, 32'h0, 0, 0, 0, 32'h0);
    run_instr(c_alu, 3'b010, 5'd9, 32'h1237, 32'hFFFFFFFF, 0, 1, 1, 32'h1237);
    run_instr(c_store, 3'b010, 5'd3, 32'h104, 32'h0, 0, 0, 0, 32'h0);

    // Stall for 3 cycles; a flushed instruction waits at the input meanwhile
    ms_valid = 1'b1; ms_ctrl = c_alu; ms_funct3 = 3'b000; ms_rd = 5'd7; ms_alu_result = 32'h12;
    @(posedge clk); #1;
    ws_stall = 1'b1;
    ms_rd = 5'd8; ms_alu_result = 32'h99; ws_flush = 1'b1;
    exp_q.push_back({5'd7, 32'h12});
    exp_instret = exp_instret + 64'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_allowin", {63'd0, ws_allowin}, 64'd0);
      chk("stall_rf_we", {63'd0, rf_we}, 64'd0);
      chk("stall_waddr", {59'd0, rf_waddr}, 64'd7);
      chk("stall_instret", instret, exp_instret - 64'd1);
      @(posedge clk); #1;
    end
    ws_stall = 1'b0; ms_valid = 1'b0; ws_flush = 1'b0;
    #1;
    chk("unstall_rf_we", {63'd0, rf_we}, 64'd1);
    @(posedge clk); #1;
    chk("post_stall_instret", instret, exp_instret);
    chk("post_stall_bubble", {63'd0, rf_we}, 64'd0);

    // Flush: neither write nor count
    run_instr(c_load, 3'b010, 5'd4, 32'h100, 32'h11111111, 1, 0, 0, 32'h0);
    // Misaligned word load: counted, not written, sticky flag set
    chk("misalign_before", {63'd0, dut.misalign_err}, 64'd0);
    run_instr(c_load, 3'b010, 5'd13, 32'h102, 32'hA5A5A5A5, 0, 0, 1, 32'hA5A5A5A5);
    chk("misalign_after", {63'd0, dut.misalign_err}, 64'd1);

    // Reset in the middle of a write-back
    ms_valid = 1'b1; ms_ctrl = c_load; ms_funct3 = 3'b010; ms_rd = 5'd11; ms_alu_result = 32'h300;
    @(posedge clk); #1;
    ms_valid = 1'b0; mem_rdata = 32'h77777777;
    #1;
    rst_n = 1'b0;
    #1;
    exp_instret = 64'd0;
    chk("midrst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("midrst_fwd_valid", {63'd0, ws_fwd_valid}, 64'd0);
    chk("midrst_instret", instret, 64'd0);
    chk("midrst_misalign", {63'd0, dut.misalign_err}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_instret", instret, 64'd0);
    chk("post_rst_rf_we", {63'd0, rf_we}, 64'd0);
    run_instr(c_load, 3'b010, 5'd12, 32'h200, 32'hCAFEF00D, 0, 1, 1, 32'hCAFEF00D);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter CNT_W, default 64, retired-instruction counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ms_valid  input  1  mem stage presents an instruction this cycle.
REQ-006 SHALL have port ms_ctrl  input  6  control: [5] branch, [4] mem_read, [3] mem_write, [2] reg_write, [1] mem_to_reg, [0] reserved.
REQ-007 SHALL have port ms_funct3  input  3  load size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-008 SHALL have port ms_rd  input  5  destination register.
REQ-009 SHALL have port ms_alu_result  input  XLEN  ALU result; bits [1:0] are the load byte offset.
REQ-010 SHALL have port mem_rdata  input  XLEN  data RAM read word, valid one cycle after the address (synchronous RAM).
REQ-011 SHALL have port ws_stall  input  1  hold the WB register.
REQ-012 SHALL have port ws_flush  input  1  kill the instruction entering WB.
REQ-013 SHALL have port ws_allowin  output  1  WB accepts a new instruction this cycle.
REQ-014 SHALL have port rf_we, rf_waddr, rf_wdata  output  1/5/XLEN  register-file write port.
REQ-015 SHALL have port ws_fwd_valid, ws_fwd_rd, ws_fwd_data  output  1/5/XLEN  forwarding to decode/execute.
REQ-016 SHALL have port instret  output  CNT_W  retired-instruction count.

Function
REQ-017 SHALL hold one pipeline register: ws_valid, ctrl, funct3, rd, alu_result, byte offset.
REQ-018 SHALL drive ws_allowin = !ws_stall.
REQ-019 SHALL load the register on ms_valid & ws_allowin; ws_valid <= ms_valid & !ws_flush; stall takes priority over flush (register unchanged).
REQ-020 SHALL clear ws_valid when ws_allowin and !ms_valid (bubble).
REQ-021 SHALL form load data combinationally in the WB cycle from mem_rdata, shifted right by 8*offset: LB/LH sign-extend, LBU/LHU zero-extend, LW unshifted.
REQ-022 SHALL treat LH/LHU with offset 3 and LW with offset != 0 as misaligned: rf_we forced 0, sticky misalign_err internal flag set (read in simulation only).
REQ-023 SHALL select rf_wdata = load data when mem_to_reg, else registered alu_result.
REQ-024 SHALL assert rf_we = ws_valid & reg_write & !ws_stall & (rd != 0) & !misaligned; at most one write per instruction.
REQ-025 SHALL drive rf_waddr = registered rd in all cycles.
REQ-026 SHALL drive ws_fwd_valid = ws_valid & reg_write & (rd != 0); ws_fwd_data = rf_wdata.
REQ-027 SHALL increment instret by 1 in each cycle ws_valid & !ws_stall, including stores, branches and misaligned loads; wraps modulo 2^CNT_W.
REQ-028 SHALL give a latency of exactly one cycle from ms_valid acceptance to rf_we.
REQ-029 SHALL, under a stall of N cycles, write the register file once, in the first unstalled cycle.

Reset
REQ-030 SHALL clear ws_valid, ctrl, rd, alu_result, offset, misalign_err and instret asynchronously when rst_n=0; rf_we=0, ws_fwd_valid=0 during reset.
REQ-031 SHALL discard an in-flight instruction on reset mid-operation, leaving no register write and no count increment.
REQ-032 SHALL release reset without a spurious write in the first cycle.

Structure
REQ-033 SHALL take ctrl bit indices, funct3 load encodings and XLEN from a shared package core_pkg.
REQ-034 SHALL place load extraction in one combinational sub-module, load_align (inputs word, offset, funct3; outputs data, misaligned).

Verification
REQ-035 LW at alu_result 0x100, rd=5, mem_rdata 0xDEADBEEF -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, instret=1.
REQ-036 LB offset 3, mem_rdata 0x80FF_0000 -> rf_wdata 0xFFFFFF80; LBU gives 0x00000080; LHU offset 2 gives 0x000080FF.
REQ-037 R-type rd=0 with reg_write -> rf_we=0, ws_fwd_valid=0, instret increments.
REQ-038 ws_stall held 3 cycles with valid ADD rd=7 result 0x12 -> single rf_we pulse after stall releases; instret +1 only.
REQ-039 ws_flush with ms_valid -> no write, no count; LW offset 2 -> rf_we=0, misalign_err=1.
REQ-040 rst_n low mid-stream -> outputs zero immediately; after release instret=0 and first write appears one cycle after the next ms_valid.
